// File: rtl/modq_pkg.sv
// modq_pkg: shared constants, FSM state type and a reference reduction helper
// for the mod-Q arbiter slice (Q = 3329).
package modq_pkg;

   localparam int N_DEFAULT    = 25;    // operand/result width in bits
   localparam int Q            = 3329;  // reduction modulus
   localparam int NREQ_DEFAULT = 4;     // requesters sharing one reducer

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Reference reduction of a signed value into 0..Q-1.
   function automatic int mod_q(input int x);
      int r;
      r = x % Q;
      if (r < 0) r = r + Q;
      return r;
   endfunction

endpackage

// File: rtl/modq_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker. The search starts one past
// ptr (mod NREQ) and returns a one-hot grant of the first set req bit.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic          found;
   logic [IW-1:0] idx;

   // Walk the requesters in rotated order and keep the first valid one.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = IW'((int'(ptr) + off) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/modq_arbiter.sv
// modq_arbiter: shares one mod-Q reduction unit among NREQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog on the WAIT state is enabled by defining MODQ_ARB_TIMEOUT_EN.
module modq_arbiter
   import modq_pkg::*;
#(
   parameter int  N              = N_DEFAULT,
   parameter int  NREQ           = NREQ_DEFAULT,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int IW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*N-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              red_start,
   output logic [N-1:0]      red_operand,
   input  logic              red_done,
   input  logic [N-1:0]      red_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic [N-1:0]      rsp_data,
   output logic              busy,
   output logic              err
);

   state_t          state_q;
   state_t          state_d;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic [N-1:0]    grant_data;
   logic            accept;
   logic            timeout;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   // Encode the one-hot grant and select the winning operand slice.
   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_idx  = IW'(i);
            grant_data = req_data[i*N +: N];
         end
      end
   end

   // Next-state and FSM outputs; everything is forced low while reset is held.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      red_start = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               req_ready = grant;
               if (|grant) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               busy      = 1'b1;
               red_start = 1'b1;
               state_d   = ST_WAIT;
            end
            ST_WAIT: begin
               busy = 1'b1;
               if (red_done || timeout) state_d = ST_RESP;
            end
            ST_RESP: begin
               busy      = 1'b1;
               rsp_valid = 1'b1;
               if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A transfer happens exactly when a one-hot ready bit is presented.
   assign accept = |req_ready;

   // State register and round-robin pointer; reset points ptr at the last
   // requester so that requester 0 wins first.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         if (accept) ptr_q <= grant_idx;
      end
   end

   // Datapath captures: operand/id on accept, result on red_done in WAIT.
   always_ff @(posedge clock) begin
      // NOTE: these data registers drive outputs that must read zero after
      // reset, so unlike pure pipeline data they are reset explicitly.
      if (reset) begin
         red_operand <= '0;
         rsp_id      <= '0;
         rsp_data    <= '0;
      end else begin
         if (accept) begin
            red_operand <= grant_data;
            rsp_id      <= grant_idx;
         end
         if (state_q == ST_WAIT && red_done) begin
            rsp_data <= red_result;
         end else if (timeout) begin
            rsp_data <= '0;
         end
      end
   end

`ifdef MODQ_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   assign timeout = (state_q == ST_WAIT) && !red_done &&
                    (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog: count cycles spent in WAIT and latch err on expiry.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                    wait_cnt <= '0;
         if (timeout) err <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout            = 1'b0;
   assign err                = 1'b0;
`endif

endmodule

// File: doc/modq_arbiter.md
MODQ_ARBITER -- requirements
Module: modq_arbiter

Interface
REQ-001 Parameter: N, 25, operand/result width in bits (two's complement in, 0..Q-1 out).
REQ-002 Parameter: NREQ, 4, number of requesters sharing one mod-Q reduction unit.
REQ-003 Parameter: TIMEOUT_CYCLES, 64, watchdog limit (used only with MODQ_ARB_TIMEOUT_EN).
REQ-004 Ports: clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Ports: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: req_valid  in  NREQ  per-requester operand valid.
REQ-007 Ports: req_data  in  NREQ*N  packed operands, requester i at bits [i*N +: N].
REQ-008 Ports: req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
REQ-009 Ports: red_start  out  1  one-cycle launch pulse to the reducer.
REQ-010 Ports: red_operand  out  N  registered operand to the reducer, stable from red_start until red_done.
REQ-011 Ports: red_done  in  1  reducer completion pulse.
REQ-012 Ports: red_result  in  N  reducer output, valid in the red_done cycle.
REQ-013 Ports: rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-014 Ports: rsp_id  out  $clog2(NREQ)  index of the requester owning rsp_data.
REQ-015 Ports: rsp_data  out  N  reduced result.
REQ-016 Ports: busy  out  1  high in every state except IDLE.
REQ-017 Ports: err  out  1  sticky timeout flag (tied 0 without MODQ_ARB_TIMEOUT_EN).

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-019 IDLE: req_ready is combinational one-hot of the round-robin winner among req_valid; all zero when no valid or not IDLE.
REQ-020 Round robin: search starts at ptr+1 mod NREQ; ptr updates to the granted index on accept.
REQ-021 Accept cycle: capture req_data slice into red_operand and index into rsp_id; go to ISSUE.
REQ-022 ISSUE: red_start=1 for exactly one cycle; go to WAIT (accept-to-start latency 1 cycle).
REQ-023 WAIT: red_done is sampled only in WAIT; on red_done capture red_result into rsp_data, go to RESP.
REQ-024 red_done outside WAIT is ignored.
REQ-025 RESP: rsp_valid=1 and rsp_data/rsp_id held until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-026 red_done-to-rsp_valid latency is 1 cycle; minimum accept-to-accept period is 4 cycles plus reducer latency.
REQ-027 Fairness: a continuously valid requester is granted within NREQ accepts.
REQ-028 A requester dropping req_valid before grant is not served; no requeue.

Reset
REQ-029 reset forces IDLE and sets ptr=NREQ-1 (first grant goes to requester 0); it drops any in-flight transaction.
REQ-030 Outputs under reset: req_ready, red_start, red_operand, rsp_valid, rsp_id, rsp_data, busy, and err are all 0.

Configuration
REQ-031 With MODQ_ARB_TIMEOUT_EN defined, a cycle counter runs in WAIT.
REQ-032 When the counter reaches TIMEOUT_CYCLES without red_done, err is set sticky and the FSM enters RESP with rsp_data=0.
REQ-033 err is cleared only by reset.
REQ-034 Without MODQ_ARB_TIMEOUT_EN, there is no counter, err=0, and WAIT waits indefinitely.

Structure
REQ-035 Shared package modq_pkg holds N, Q=3329, the FSM state typedef and the NREQ default.
REQ-036 Sub-module rr_arbiter (req vector, ptr -> one-hot grant) is instantiated once; all other logic is in modq_arbiter.

Verification
REQ-037 Single request: req_valid=0001, data=7000, reducer model returns 342 after 3 cycles -> red_start 1 cycle after accept, rsp_valid 1 cycle after red_done, rsp_id=0, rsp_data=342.
REQ-038 All four valid continuously -> grant order 0,1,2,3,0; there are never two req_ready bits set at once.
REQ-039 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_data/rsp_id stable, req_ready all 0, busy=1.
REQ-040 Spurious red_done in IDLE and ISSUE -> no state change; a negative operand of -1 passes through unmodified on red_operand.
REQ-041 Reset asserted in WAIT -> next cycle IDLE, all outputs 0, next grant to requester 0.
REQ-042 With MODQ_ARB_TIMEOUT_EN, withhold red_done -> err=1 after 64 WAIT cycles, rsp_valid with rsp_data=0, err stays 1 until reset.
